// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add/sub on one 4-bit CLA slice,
// one nibble per cycle, LSB first, valid/ready on both sides.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     request handshake; a, b, sub operands
//   out_valid/out_ready   result handshake; sum, cout, ovf, zero
//   busy                  high while nibbles are being processed

module fastcarry_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s    = p ^ c[3:0];
  assign cout = c[4];

endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_chk
    $error("WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } st_t;

  st_t state_q;
  st_t state_d;

  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_q;

  logic             accept;
  logic             last;
  logic             dn;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [3:0]       nib_s;
  logic             nib_co;
  logic             msb_cin;

  // Operands are shifted so the active nibble lands in [3:0].
  assign a_sh = a_r >> {idx_q, 2'b00};
  assign b_sh = b_r >> {idx_q, 2'b00};

  fastcarry_4 u_cla (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_co)
  );

  assign last   = (idx_q == LAST);
  assign accept = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sum_q   <= '0;
    end else begin
      if (accept) begin
        a_r     <= a;
        b_r     <= sub ? ~b : b;
        carry_q <= sub;
        idx_q   <= '0;
        sum_q   <= '0;
      end else if (state_q == RUN) begin
        // sum is cleared on acceptance, so OR-ing each nibble in is exact.
        sum_q   <= sum_q
                 | (WIDTH'(nib_s) << {idx_q, 2'b00});
        carry_q <= nib_co;
        if (!last) idx_q <= idx_q + IW'(1);
      end
    end
  end

  // b_r already holds ~b for subtract, so this is the true MSB carry-in.
  assign msb_cin = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ sum_q[WIDTH-1];

  assign dn   = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = dn & carry_q;
  assign ovf  = dn & (msb_cin ^ carry_q);
  assign zero = dn & (sum_q == '0);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: vector table plus scoreboard bench
// for nibble_serial_adder_ctrl at WIDTH=16.

module tb_nibble_serial_adder_ctrl;

  logic        clk;
  logic        clk_on;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        busy;

  int checks;
  int errors;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  exp_t sb[$];
  vec_t vt[9];

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 if (clk_on) clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op, push its expectation, then wait for and check result.
  task automatic run_op(input vec_t v, input string nm);
    int n;
    int nb;
    logic acc;
    exp_t e;
    exp_t got;
    in_valid = 1'b1;
    a = v.a;
    b = v.b;
    sub = v.sub;
    n = 0;
    do begin
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sub = $urandom_range(0, 1);
    if (!acc) begin
      chk({nm, "_accept_timeout"}, 0, 1);
      return;
    end
    e = '{s: v.s, c: v.c, v: v.v, z: v.z};
    sb.push_back(e);
    n = 0;
    nb = 0;
    while (!out_valid && n < 20) begin
      if (busy) nb++;
      tick();
      n++;
    end
    chk({nm, "_latency"}, n, 4);
    chk({nm, "_busy_cycles"}, nb, 4);
    if (!out_valid) return;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 0, 1);
      return;
    end
    got = '{s: sum, c: cout, v: ovf, z: zero};
    e = sb.pop_front();
    chk({nm, "_sum"}, got.s, e.s);
    chk({nm, "_cout"}, got.c, e.c);
    chk({nm, "_ovf"}, got.v, e.v);
    chk({nm, "_zero"}, got.z, e.z);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_drop_valid"}, out_valid, 0);
    chk({nm, "_idle_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [15:0] hs;
    logic [2:0]  hf;
    int          seen;
    int          n;
    checks = 0;
    errors = 0;
    clk_on = 1'b0;
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;

    vt[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vt[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vt[4] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vt[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[6] = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vt[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vt[8] = '{16'h00FF, 16'h0101, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b0};

    // Asynchronous reset with the clock stopped.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, ovf, zero}, 0);
    clk_on = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++)
      run_op(vt[i], $sformatf("vec%0d", i));

    // Backpressure: result held while requester keeps poking.
    in_valid = 1'b1;
    a = vt[0].a;
    b = vt[0].b;
    sub = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp_latency", n, 4);
    hs = sum;
    hf = {cout, ovf, zero};
    chk("bp_sum", hs, 16'h2201);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = $urandom;
      b = $urandom;
      tick();
      chk($sformatf("bp_hold_sum%0d", i), sum, hs);
      chk($sformatf("bp_hold_flags%0d", i), hf, {cout, ovf, zero});
      chk($sformatf("bp_ready%0d", i), in_ready, 0);
      chk($sformatf("bp_valid%0d", i), out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_idle", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    run_op(vt[6], "bp_next");

    // Reset in the middle of RUN aborts the op.
    in_valid = 1'b1;
    a = 16'h00AA;
    b = 16'h0055;
    sub = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("mr_busy", busy, 1);
    out_ready = 1'b1;
    repeat (2) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("mr_in_ready", in_ready, 1);
    chk("mr_busy_low", busy, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_sum", sum, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    chk("mr_no_valid", seen, 0);
    run_op(vt[8], "mr_fresh");

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that computes a WIDTH-bit add or subtract on one 4-bit carry-lookahead adder slice, time-shared over the operand nibbles.
- Processes one nibble per cycle, LSB first, and chains carry-out to carry-in through a carry register.
- Sits between a valid/ready requester and a valid/ready consumer.
- Instantiates the team's fastcarry_4 as the only arithmetic datapath.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4; any other value is an elaboration error.
- NIB, WIDTH/4 (derived, not overridable), number of nibble passes per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request presents an operation
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0: A+B; 1: A-B
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (subtract: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow
- zero  output  1  sum == 0
- busy  output  1  operation in progress (state RUN)

Behaviour:
- One clock domain.
- rst_n low, asynchronously:
  - state = IDLE; nibble index, carry register and operand registers = 0.
  - sum = 0, cout = 0, ovf = 0, zero = 0, out_valid = 0, busy = 0.
  - in_ready = 1, because in_ready is combinational (state == IDLE).
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at a rising edge: latch a into a_r; latch b into b_r (~b when sub = 1); carry register = sub; index = 0; sum register = 0; go to RUN.
  - Inputs are sampled only at the accepting edge; later changes are ignored.
- RUN:
  - in_ready = 0, busy = 1.
  - Each cycle, the adder receives nibble[index] of a_r, nibble[index] of b_r, and the carry register.
  - At the edge: sum[4*index+3:4*index] = S; carry register = Cout; index increments.
  - On the edge where index == NIB-1, go to DONE. RUN lasts exactly NIB cycles.
- DONE:
  - out_valid = 1, busy = 0, in_ready = 0.
  - cout = carry register.
  - ovf = carry into bit WIDTH-1 XOR cout, where carry into MSB = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ sum[WIDTH-1].
  - zero = (sum == 0).
  - sum, cout, ovf and zero are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: go to IDLE and drop out_valid.
  - The result registers keep their last value until the next acceptance.
  - cout, ovf and zero are meaningful only while out_valid = 1.
- Latency:
  - out_valid rises NIB cycles after the accepting edge (WIDTH=16: 4 cycles).
  - Minimum issue interval is NIB+2 cycles; there is no overlap of DONE with the next acceptance.
- Boundaries:
  - in_valid asserted during RUN or DONE: not accepted. The requester must hold it until in_ready.
  - out_ready high before DONE: no effect.
  - rst_n low mid-RUN or in DONE: the operation is aborted immediately and no out_valid is produced.
  - After reset release the block is in IDLE and the next accepted operation is computed from fresh operands.
  - Index wrap: index never exceeds NIB-1 and is cleared on acceptance.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- Reset: drive rst_n low mid-cycle with clk stopped -> all outputs at reset values immediately; in_ready = 1, out_valid = 0.
- Add latency (WIDTH=16): a=0x1234, b=0x0FCD, sub=0 accepted at edge E -> out_valid rises at E+4 with sum=0x2201, cout=0, ovf=0, zero=0; busy high for exactly 4 cycles.
- Full carry ripple and overflow:
  - 0xFFFF+0x0001 -> sum=0x0000, cout=1, zero=1, ovf=0.
  - 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract:
  - 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - 0x0003-0x0005 -> sum=0xFFFE, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a and b -> sum/flags stable, in_ready=0, nothing accepted. Raise out_ready -> IDLE next cycle, then a new operation is accepted.
- Reset mid-RUN: assert rst_n low after 2 RUN cycles -> immediate IDLE, no out_valid ever produced. Release, issue 0x00FF+0x0101 -> sum=0x0200 after 4 cycles.
